memory_stage: RTL and testbench

- Memory stage of the SIMD AES pipeline. Sits directly downstream of execute, behind register_EM.
- Performs scalar (32-bit) and vector (256-bit) loads and stores against a 32-bit-wide data memory that uses a req/ready handshake.
- Vector accesses are split into V/N sequential word beats.
- Asserts StallM to the hazard unit until the access completes.

---
 rtl/memory_stage.sv | 211 +++++++++++++++++++++
 tb/tb_memory_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage -- memory stage of the SIMD AES pipeline.
//
// Sits behind register_EM and performs scalar (N-bit) and vector (V-bit)
// loads/stores against an N-bit data memory with a req/ready handshake.
// A vector access is issued as L = V/N sequential word beats in lane order.
// StallM holds the upstream pipeline until the access has completed.
//
// Optional build macro: MEM_TIMEOUT_EN
//   Defined   : a per-beat wait counter aborts a beat that has waited TIMEOUT
//               cycles, sets the sticky MemErrM and zero-fills the unread part
//               of a load result.
//   Undefined : beats wait indefinitely and MemErrM is tied to 0.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   ALUResultM   byte address from execute (low two bits ignored)
//   WriteDataM   scalar store data
//   WriteDataVM  vector store data, lane i = bits [N*i+N-1 : N*i]
//   MemWriteM    store request (wins if MemtoRegM is also high)
//   MemtoRegM    load request
//   VecDataM     1 = vector access (L beats), 0 = scalar (1 beat)
//   MemReady     memory accepted/completed the current beat
//   MemRD        memory read data, valid with MemReady
//   MemReq       beat request to memory
//   MemWE        beat is a write
//   MemAddr      beat word address
//   MemWD        beat write data
//   ReadDataM    registered scalar load result
//   ReadDataVM   registered vector load result
//   StallM       stall request to the hazard unit
//   MemErrM      sticky beat-timeout error
module memory_stage #(
  parameter int unsigned N       = 32,
  parameter int unsigned V       = 256,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ALUResultM,
  input  logic [N-1:0] WriteDataM,
  input  logic [V-1:0] WriteDataVM,
  input  logic         MemWriteM,
  input  logic         MemtoRegM,
  input  logic         VecDataM,
  input  logic         MemReady,
  input  logic [N-1:0] MemRD,
  output logic         MemReq,
  output logic         MemWE,
  output logic [N-1:0] MemAddr,
  output logic [N-1:0] MemWD,
  output logic [N-1:0] ReadDataM,
  output logic [V-1:0] ReadDataVM,
  output logic         StallM,
  output logic         MemErrM
);

  localparam int unsigned L  = V / N;
  localparam int unsigned BW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT         state;
  stateT         nextState;
  logic [BW-1:0] beat;
  logic [N-1:0]  base;
  logic          isStore;
  logic          isVec;

  logic          opPresent;
  logic          lastBeat;
  logic          abort;
  logic [N-1:0]  laneWD;
  logic [1:0]    unusedAddrBits;

  assign opPresent      = MemWriteM | MemtoRegM;
  assign lastBeat       = isVec ? (beat == BW'(L - 1)) : (beat == '0);
  assign laneWD         = WriteDataVM[32'(beat) * N +: N];
  // Accesses are word aligned; the byte offset is dropped without a fault.
  assign unusedAddrBits = ALUResultM[1:0];

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] waitCnt;
  logic          memErr;

  // Abort on the edge that would bring the wait count up to TIMEOUT.
  assign abort = (state == BUSY) && !MemReady && (waitCnt == TW'(TIMEOUT - 1));

  // Cleared whenever a new beat starts (entry from IDLE or beat accepted).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
    end else if (state != BUSY || MemReady) begin
      waitCnt <= '0;
    end else begin
      waitCnt <= waitCnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memErr <= 1'b0;
    end else if (abort) begin
      memErr <= 1'b1;
    end
  end

  assign MemErrM = memErr;
`else
  assign abort   = 1'b0;
  assign MemErrM = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; DONE keeps the still-frozen op from re-triggering.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (opPresent) nextState = BUSY;
      BUSY: begin
        if ((MemReady && lastBeat) || abort) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic. StallM is gated by rst so it drops with the async reset
  // even while the frozen op inputs are still asserted.
  always_comb begin
    MemReq  = 1'b0;
    MemWE   = 1'b0;
    MemAddr = '0;
    MemWD   = '0;
    StallM  = 1'b0;
    case (state)
      IDLE: StallM = opPresent & ~rst;
      BUSY: begin
        MemReq  = 1'b1;
        StallM  = 1'b1;
        MemWE   = isStore;
        MemAddr = base + (N'(beat) << 2);
        MemWD   = isVec ? laneWD : WriteDataM;
      end
      default: ;
    endcase
  end

  // Access context and load result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base       <= '0;
      beat       <= '0;
      isStore    <= 1'b0;
      isVec      <= 1'b0;
      ReadDataM  <= '0;
      ReadDataVM <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (opPresent) begin
            base    <= {ALUResultM[N-1:2], 2'b00};
            beat    <= '0;
            isStore <= MemWriteM;
            isVec   <= VecDataM;
          end
        end
        BUSY: begin
          if (MemReady) begin
            if (!isStore) begin
              if (isVec) begin
                ReadDataVM[32'(beat) * N +: N] <= MemRD;
              end else begin
                ReadDataM <= MemRD;
              end
            end
            if (!lastBeat) begin
              beat <= beat + BW'(1);
            end
          end else if (abort && !isStore) begin
            // Lanes not yet read (current beat onward) are zero-filled.
            if (isVec) begin
              for (int unsigned i = 0; i < L; i++) begin
                if (i >= 32'(beat)) begin
                  ReadDataVM[i * N +: N] <= '0;
                end
              end
            end else begin
              ReadDataM <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage -- directed scoreboard bench for memory_stage.
// Each access pushes its expected memory beats (address, write enable, write
// data) to a queue; beats are popped and compared as the DUT issues them.
// Load results, stall length and error flag are compared against values the
// bench computes itself.
module tb_memory_stage;

  localparam int N = 32;
  localparam int V = 256;
  localparam int L = V / N;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } beatT;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] ALUResultM;
  logic [N-1:0] WriteDataM;
  logic [V-1:0] WriteDataVM;
  logic         MemWriteM;
  logic         MemtoRegM;
  logic         VecDataM;
  logic         MemReady;
  logic [N-1:0] MemRD;
  logic         MemReq;
  logic         MemWE;
  logic [N-1:0] MemAddr;
  logic [N-1:0] MemWD;
  logic [N-1:0] ReadDataM;
  logic [V-1:0] ReadDataVM;
  logic         StallM;
  logic         MemErrM;

  int   checks   = 0;
  int   failures = 0;
  beatT q[$];

  logic [N-1:0] wd;
  logic [V-1:0] wdv;
  logic [V-1:0] expVM;
  logic [N-1:0] expRD;

  memory_stage #(.N(N), .V(V), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .WriteDataVM(WriteDataVM),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .VecDataM   (VecDataM),
    .MemReady   (MemReady),
    .MemRD      (MemRD),
    .MemReq     (MemReq),
    .MemWE      (MemWE),
    .MemAddr    (MemAddr),
    .MemWD      (MemWD),
    .ReadDataM  (ReadDataM),
    .ReadDataVM (ReadDataVM),
    .StallM     (StallM),
    .MemErrM    (MemErrM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected vector load image: lane i = rdBase*(i+1) for lanes below nLoaded, else 0.
  function automatic logic [V-1:0] vecImage(input logic [31:0] rdBase, input int nLoaded);
    logic [V-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++) begin
      if (i < nLoaded) r[i*N +: N] = rdBase * 32'(i + 1);
    end
    return r;
  endfunction

  // Runs one access starting in IDLE at posedge+1; returns at posedge+1 in IDLE.
  // Memory returns rdBase*(beat+1) and withholds MemReady for waitN cycles on waitBeat.
  task automatic doAccess(input logic st, input logic ld, input logic vec,
                          input logic [31:0] addr, input logic [31:0] rdBase,
                          input int waitBeat, input int waitN,
                          input int expStall, input int expLeft);
    int   nb;
    int   b;
    int   waited;
    int   stall;
    bit   fin;
    beatT e;
    nb = vec ? L : 1;
    for (int i = 0; i < nb; i++) begin
      e.addr = {addr[31:2], 2'b00} + 32'(4 * i);
      e.we   = st;
      e.wd   = vec ? wdv[i*N +: N] : wd;
      q.push_back(e);
    end
    MemWriteM   = st;
    MemtoRegM   = ld;
    VecDataM    = vec;
    ALUResultM  = addr;
    WriteDataM  = wd;
    WriteDataVM = wdv;
    b = 0; waited = 0; stall = 0; fin = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      // MemReady is driven high outside BUSY as well; the DUT must ignore it.
      if (MemReq && b == waitBeat && waited < waitN) begin
        MemReady = 1'b0;
        waited++;
      end else begin
        MemReady = 1'b1;
      end
      MemRD = rdBase * 32'(b + 1);
      #1;
      if (!StallM) begin
        fin       = 1;
        MemWriteM = 1'b0;
        MemtoRegM = 1'b0;
      end else begin
        stall++;
        if (MemReq) begin
          if (q.size() == 0) begin
            check("extraBeat", 1, 0);
          end else begin
            e = MemReady ? q.pop_front() : q[0];
            check("MemAddr", MemAddr, e.addr);
            check("MemWE", MemWE, e.we);
            check("MemWD", MemWD, e.wd);
            if (MemReady) b++;
          end
        end
      end
      @(posedge clk); #1;
    end
    if (!fin) check("accessTimeout", 0, 1);
    check("stallCycles", stall, expStall);
    check("beatsLeft", q.size(), expLeft);
    q.delete();
    MemReady = 1'b0;
  endtask

  initial begin
    int  b;
    bit  hit;
    rst = 1'b1;
    ALUResultM = '0; WriteDataM = '0; WriteDataVM = '0;
    MemWriteM = 1'b0; MemtoRegM = 1'b0; VecDataM = 1'b0;
    MemReady = 1'b0; MemRD = '0;
    wd = '0; wdv = '0;
    #12;
    check("rstMemReq", MemReq, 0);
    check("rstStallM", StallM, 0);
    check("rstReadDataM", ReadDataM, 0);
    check("rstReadDataVM", ReadDataVM, 0);
    check("rstMemErrM", MemErrM, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Scalar store, zero wait
    wd = 32'hDEADBEEF;
    doAccess(1, 0, 0, 32'h0000_0010, 32'h0, -1, 0, 2, 0);

    // Vector load, zero wait, back-to-back with previous op
    doAccess(0, 1, 1, 32'h0000_0100, 32'h1111_1111, -1, 0, 9, 0);
    expVM = vecImage(32'h1111_1111, L);
    check("vecLoad", ReadDataVM, expVM);
    check("vecLoadLane7", ReadDataVM[255:224], 32'h8888_8888);

    // Scalar load with 2 waits on its beat
    doAccess(0, 1, 0, 32'h0000_0046, 32'hA5A5_0001, 0, 2, 4, 0);
    expRD = 32'hA5A5_0001;
    check("scalarLoad", ReadDataM, expRD);
    check("vecHeldAfterScalar", ReadDataVM, expVM);

    // Vector store, MemReady low 3 cycles on beat 2
    for (int i = 0; i < L; i++) wdv[i*N +: N] = 32'hC0DE_0000 + 32'(i);
    doAccess(1, 0, 1, 32'h0000_0300, 32'h5555_0000, 2, 3, 12, 0);
    check("vecHeldAfterStore", ReadDataVM, expVM);
    check("scalarHeldAfterStore", ReadDataM, expRD);

    // Store and load both requested: treated as store
    wd = 32'h1234_5678;
    doAccess(1, 1, 0, 32'h0000_0080, 32'h9999_9999, -1, 0, 2, 0);
    check("bothHighNoLoad", ReadDataM, expRD);

    // Address wrap with misaligned base
    doAccess(0, 1, 1, 32'hFFFF_FFF3, 32'h0101_0101, -1, 0, 9, 0);
    expVM = vecImage(32'h0101_0101, L);
    check("wrapLoad", ReadDataVM, expVM);
    check("wrapNoErr", MemErrM, 0);

    // Reset in the middle of a vector load (during beat 3)
    ALUResultM = 32'h0000_0200; VecDataM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    b = 0; hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (MemReq && b == 3) begin
        hit = 1;
      end else begin
        MemReady = 1'b1;
        MemRD    = 32'h7700_0000 + 32'(b);
        #1;
        if (MemReq && MemReady) b++;
        @(posedge clk); #1;
      end
    end
    check("reachedBeat3", hit, 1);
    MemReady = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midRstMemReq", MemReq, 0);
    check("midRstStallM", StallM, 0);
    check("midRstReadDataVM", ReadDataVM, 0);
    check("midRstMemAddr", MemAddr, 0);
    MemtoRegM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    doAccess(0, 1, 1, 32'h0000_0040, 32'h0000_0003, -1, 0, 9, 0);
    check("postRstLoad", ReadDataVM, vecImage(32'h0000_0003, L));

`ifdef MEM_TIMEOUT_EN
    // MemReady stuck low on beat 5: abort after 4 wait cycles
    doAccess(0, 1, 1, 32'h0000_0500, 32'h0001_0001, 5, 1000, 10, 3);
    check("timeoutErr", MemErrM, 1);
    check("timeoutLanes", ReadDataVM, vecImage(32'h0001_0001, 5));
    wd = 32'h0BAD_F00D;
    doAccess(1, 0, 0, 32'h0000_0600, 32'h0, -1, 0, 2, 0);
    check("errSticky", MemErrM, 1);
`else
    check("noTimeoutErr", MemErrM, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
